// File: rtl/uart_rx_packetizer.sv
// Packs UART receiver bytes into fixed-length, checksum-validated packets on a held output register.
// Latency: packet_valid rises 1 clk after the checksum byte strobe; error pulses are also 1 clk late.
// Backpressure: a good packet arriving while the previous one is unacked is dropped and flagged as overrun.
module uart_rx_packetizer #(
    parameter int PACKET_BYTES = 44,
    parameter int CNT_W        = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_data_ready,
    input  logic                      rx_error,
    input  logic                      rx_busy,
    output logic [8*PACKET_BYTES-1:0] packet_data,
    output logic                      packet_valid,
    input  logic                      packet_ack,
    output logic                      receiving,
    output logic                      err_checksum,
    output logic                      err_framing,
    output logic                      err_timeout,
    output logic                      err_overrun
);

    localparam int DW = 8 * PACKET_BYTES;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DW-1:0]    shreg;
    logic [DW-1:0]    shreg_shifted;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       sum;
    logic [7:0]       sum_total;

    logic             start;
    logic             accum;
    logic             complete;
    logic             clr;
    logic             framing_nxt;
    logic             timeout_nxt;
    logic             chk_good;
    logic             publish;
    logic             overrun_nxt;
    logic             checksum_nxt;

    // New byte enters at the top so the first byte of a packet ends at [7:0].
    assign shreg_shifted = (shreg >> 8) | (DW'(rx_byte) << (DW - 8));
    assign sum_total     = sum + rx_byte;

    assign chk_good      = complete && (sum_total == 8'h00);
    assign publish       = chk_good && (!packet_valid || packet_ack);
    assign overrun_nxt   = chk_good && packet_valid && !packet_ack;
    assign checksum_nxt  = complete && (sum_total != 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        accum       = 1'b0;
        complete    = 1'b0;
        clr         = 1'b0;
        framing_nxt = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_error) begin
                    framing_nxt = 1'b1;
                    state_nxt   = S_DISCARD;
                end else if (rx_data_ready) begin
                    start     = 1'b1;
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_error) begin
                    framing_nxt = 1'b1;
                    clr         = 1'b1;
                    state_nxt   = S_DISCARD;
                end else if (rx_data_ready) begin
                    // A byte arriving on the same clk as a gap wins over the gap.
                    if (cnt == CNT_W'(PACKET_BYTES)) begin
                        complete  = 1'b1;
                        clr       = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        accum = 1'b1;
                    end
                end else if (!rx_busy) begin
                    timeout_nxt = 1'b1;
                    clr         = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!rx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                clr       = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            sum   <= 8'h00;
        end else if (start) begin
            shreg <= shreg_shifted;
            cnt   <= CNT_W'(1);
            sum   <= rx_byte;
        end else if (accum) begin
            shreg <= shreg_shifted;
            cnt   <= cnt + CNT_W'(1);
            sum   <= sum_total;
        end else if (clr) begin
            cnt   <= '0;
            sum   <= 8'h00;
        end
    end

    // The shift register keeps assembling while packet_data is held for the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            packet_data  <= '0;
            packet_valid <= 1'b0;
        end else if (publish) begin
            packet_data  <= shreg;
            packet_valid <= 1'b1;
        end else if (packet_valid && packet_ack) begin
            packet_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            receiving    <= 1'b0;
            err_checksum <= 1'b0;
            err_framing  <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            receiving    <= (state_nxt == S_RECV);
            err_checksum <= checksum_nxt;
            err_framing  <= framing_nxt;
            err_timeout  <= timeout_nxt;
            err_overrun  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed and randomized checks of uart_rx_packetizer with PACKET_BYTES=4 against a packet-level model.
module tb_uart_rx_packetizer;

    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_byte;
    logic          rx_data_ready;
    logic          rx_error;
    logic          rx_busy;
    logic [8*PB-1:0] packet_data;
    logic          packet_valid;
    logic          packet_ack;
    logic          receiving;
    logic          err_checksum;
    logic          err_framing;
    logic          err_timeout;
    logic          err_overrun;

    uart_rx_packetizer #(.PACKET_BYTES(PB), .CNT_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_data_ready (rx_data_ready),
        .rx_error      (rx_error),
        .rx_busy       (rx_busy),
        .packet_data   (packet_data),
        .packet_valid  (packet_valid),
        .packet_ack    (packet_ack),
        .receiving     (receiving),
        .err_checksum  (err_checksum),
        .err_framing   (err_framing),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_cs = 0, n_fr = 0, n_to = 0, n_ov = 0;
    int e_cs = 0, e_fr = 0, e_to = 0, e_ov = 0;

    // Packet-level reference: bytes of the current packet in a queue plus a discarding flag.
    bit            m_valid = 1'b0;
    logic [8*PB-1:0] m_data = '0;
    logic [7:0]    q[$];
    bit            m_disc = 1'b0;

    always @(negedge clk) begin
        if (err_checksum) n_cs++;
        if (err_framing)  n_fr++;
        if (err_timeout)  n_to++;
        if (err_overrun)  n_ov++;
        if (!reset) begin
            n_asserts++;
            assert ($onehot0({err_checksum, err_framing, err_timeout, err_overrun}))
            else begin
                n_fail++;
                $error("FAIL err_onehot: observed %b required at most one bit set",
                       {err_checksum, err_framing, err_timeout, err_overrun});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] good_cks(input logic [8*PB-1:0] payload);
        int s = 0;
        for (int k = 0; k < PB; k++) s += payload[8*k +: 8];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_valid"},   64'(packet_valid), 64'(m_valid));
        chk({tag, "_data"},    64'(packet_data),  64'(m_data));
        chk({tag, "_recv"},    64'(receiving),    64'(!m_disc && q.size() > 0));
        chk({tag, "_n_cs"},    64'(n_cs), 64'(e_cs));
        chk({tag, "_n_fr"},    64'(n_fr), 64'(e_fr));
        chk({tag, "_n_to"},    64'(n_to), 64'(e_to));
        chk({tag, "_n_ov"},    64'(n_ov), 64'(e_ov));
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ack);
        bit pub = 1'b0;
        if (!m_disc) begin
            q.push_back(b);
            if (q.size() == PB + 1) begin
                int s = 0;
                foreach (q[i]) s += q[i];
                if (s % 256 == 0) begin
                    if (!m_valid || ack) begin
                        for (int k = 0; k < PB; k++) m_data[8*k +: 8] = q[k];
                        pub = 1'b1;
                    end else begin
                        e_ov++;
                    end
                end else begin
                    e_cs++;
                end
                q.delete();
            end
        end
        if (pub) m_valid = 1'b1;
        else if (ack) m_valid = 1'b0;
    endtask

    task automatic byte_op(input logic [7:0] b, input bit ack);
        @(negedge clk);
        rx_byte       = b;
        rx_data_ready = 1'b1;
        packet_ack    = ack;
        @(negedge clk);
        rx_data_ready = 1'b0;
        packet_ack    = 1'b0;
        model_byte(b, ack);
    endtask

    task automatic err_op();
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        if (!m_disc) begin
            e_fr++;
            m_disc = 1'b1;
            q.delete();
        end
    endtask

    task automatic gap_op();
        @(negedge clk);
        rx_busy = 1'b0;
        @(negedge clk);
        rx_busy = 1'b1;
        if (m_disc) begin
            m_disc = 1'b0;
        end else if (q.size() > 0) begin
            e_to++;
            q.delete();
        end
    endtask

    task automatic ack_op();
        @(negedge clk);
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [8*PB-1:0] payload, input logic [7:0] ck,
                            input bit ack_last, input string tag);
        for (int k = 0; k < PB; k++) begin
            byte_op(payload[8*k +: 8], 1'b0);
            check_all({tag, "_b"});
        end
        byte_op(ck, ack_last);
        check_all({tag, "_ck"});
    endtask

    initial begin
        logic [8*PB-1:0] pa;
        logic [8*PB-1:0] pb;
        reset         = 1'b1;
        rx_byte       = 8'h00;
        rx_data_ready = 1'b0;
        rx_error      = 1'b0;
        rx_busy       = 1'b1;
        packet_ack    = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset_err", 64'({err_checksum, err_framing, err_timeout, err_overrun}), 64'(0));
        reset = 1'b0;

        // Good packet, then ack.
        pa = 32'h04030201;
        send_pkt(pa, 8'hF6, 1'b0, "good1");
        chk("good1_const", 64'(packet_data), 64'(32'h04030201));
        chk("good1_v1", 64'(packet_valid), 64'(1));
        ack_op();
        check_all("ack1");

        // Bad checksum, then a good one.
        send_pkt(pa, 8'h00, 1'b0, "bad");
        send_pkt(32'h40302010, 8'h60, 1'b0, "good2");
        chk("good2_const", 64'(packet_data), 64'(32'h40302010));
        ack_op();

        // Timeout mid-packet.
        byte_op(8'h01, 1'b0);
        byte_op(8'h02, 1'b0);
        check_all("partial");
        gap_op();
        check_all("timeout");
        send_pkt(pa, 8'hF6, 1'b0, "after_to");
        ack_op();

        // Framing error, trailing bytes ignored until the line goes idle.
        byte_op(8'h01, 1'b0);
        err_op();
        byte_op(8'h02, 1'b0);
        byte_op(8'h03, 1'b0);
        byte_op(8'h04, 1'b0);
        byte_op(8'hF6, 1'b0);
        check_all("discard");
        gap_op();
        send_pkt(pa, 8'hF6, 1'b0, "after_fr");
        ack_op();

        // Overrun, then ack coinciding with the second checksum strobe.
        pb = 32'h08070605;
        send_pkt(pa, 8'hF6, 1'b0, "ov_a");
        send_pkt(pb, good_cks(pb), 1'b0, "ov_b");
        chk("ov_keep", 64'(packet_data), 64'(32'h04030201));
        ack_op();
        send_pkt(pa, 8'hF6, 1'b0, "ackov_a");
        send_pkt(pb, good_cks(pb), 1'b1, "ackov_b");
        chk("ackov_data", 64'(packet_data), 64'(32'h08070605));
        chk("ackov_valid", 64'(packet_valid), 64'(1));

        // Asynchronous reset mid-packet with a packet held.
        byte_op(8'h11, 1'b0);
        byte_op(8'h22, 1'b0);
        byte_op(8'h33, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_disc  = 1'b0;
        q.delete();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        send_pkt(pa, 8'hF6, 1'b0, "post_rst");
        ack_op();

        // Randomized mix of operations.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    pa = $urandom;
                    send_pkt(pa, good_cks(pa), 1'($urandom_range(0, 1)), "rnd_good");
                end
                2: begin
                    pa = $urandom;
                    send_pkt(pa, good_cks(pa) + 8'($urandom_range(1, 255)), 1'b0, "rnd_bad");
                end
                3: begin
                    ack_op();
                    check_all("rnd_ack");
                end
                4: begin
                    for (int k = $urandom_range(1, PB); k > 0; k--) byte_op(8'($urandom), 1'b0);
                    gap_op();
                    check_all("rnd_to");
                end
                default: begin
                    for (int k = $urandom_range(0, PB); k > 0; k--) byte_op(8'($urandom), 1'b0);
                    err_op();
                    for (int k = $urandom_range(0, 3); k > 0; k--) byte_op(8'($urandom), 1'b0);
                    check_all("rnd_disc");
                    gap_op();
                    check_all("rnd_fr");
                end
            endcase
        end

        repeat (2) @(negedge clk);
        check_all("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
